// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - Shared RISC-V core constants, fetch state type and PC helpers
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam logic [XLEN-1:0] WORD_MASK        = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic {
        FETCH,
        FLUSH
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Synchronous FIFO with flush, used for the instruction queue and PC tags
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch front end: PC, credit-limited requests, redirect flush
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t      state, state_next;
    logic [XLEN-1:0]   pc;
    logic [CW-1:0]     stale, stale_next, stale_cur;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     occupancy;
    logic [XLEN-1:0]   tag_head;
    logic [3*XLEN-1:0] iq_head;
    logic              iq_full, iq_empty, tag_full, tag_empty;
    logic              credit_ok, accept, fresh_rsp, pop, iq_push, tag_pop;

    assign instr_valid = !iq_empty;
    assign pop         = instr_valid && instr_ready;
    assign {instr_data, instr_pc, instr_pc_plus4} = iq_head;

    // A head leaving this cycle frees its slot for the next request.
    always_comb begin
        credit_ok      = (int'(occupancy) + int'(outstanding) - int'(pop)) < QUEUE_DEPTH;
        imem_req_valid = (state == FETCH) && !rst && !redirect_valid && !tag_full && credit_ok;
        imem_req_addr  = pc;
        accept         = imem_req_valid && imem_req_ready;
        fresh_rsp      = imem_rsp_valid && (state == FETCH) && !redirect_valid;
        iq_push        = fresh_rsp && !iq_full;
        tag_pop        = fresh_rsp && !tag_empty;
    end

    // Responses still in flight at a redirect become stale and are counted down.
    always_comb begin
        state_next = state;
        stale_next = stale;
        stale_cur  = (state == FETCH) ? outstanding : stale;
        if (redirect_valid || state == FLUSH) begin
            stale_next = stale_cur - ((imem_rsp_valid && stale_cur != '0) ? CW'(1) : CW'(0));
            state_next = (stale_next == '0) ? FETCH : FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            stale <= '0;
            pc    <= word_align(RESET_PC);
        end else begin
            state <= state_next;
            stale <= stale_next;
            if (redirect_valid) begin
                pc <= word_align(redirect_pc);
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH),
        .WIDTH(3*XLEN)
    ) u_instr_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (iq_push),
        .push_data({imem_rsp_data, tag_head, tag_head + 32'd4}),
        .pop      (pop),
        .head_data(iq_head),
        .full     (iq_full),
        .empty    (iq_empty),
        .count    (occupancy)
    );

    // The tag FIFO depth doubles as the count of live (non-stale) requests.
    fetch_queue #(
        .DEPTH(QUEUE_DEPTH),
        .WIDTH(XLEN)
    ) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (accept),
        .push_data(pc),
        .pop      (tag_pop),
        .head_data(tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (outstanding)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Scoreboard bench for fetch_unit with a randomized in-order memory model
module tb_fetch_unit;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_pc_plus4(instr_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          consumed = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          last_due = 0;
    int          mdue;
    logic [31:0] mexp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_seq(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        push_seq(RPC);
        req_log.delete();
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc = t;
        exp_q.delete();
        push_seq(t & 32'hFFFF_FFFC);
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr_data"}, instr_data, 32'd0);
        check({tag, "_instr_pc"}, instr_pc, 32'd0);
        check({tag, "_instr_pc4"}, instr_pc_plus4, 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: accepts at the upcoming edge, answers in order after a random latency.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(99) < ready_pct);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            if (pend.size() > 0) begin
                if (pend[0].due <= cyc + 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend[0].addr);
                end
            end
            #4;
            if (rst) begin
                pend.delete();
                last_due = 0;
            end else begin
                if (imem_rsp_valid) void'(pend.pop_front());
                if (imem_req_valid && imem_req_ready) begin
                    mdue = cyc + 1 + int'($urandom_range(lat_max, lat_min));
                    if (mdue <= last_due) mdue = last_due + 1;
                    last_due = mdue;
                    pend.push_back('{addr: imem_req_addr, due: mdue});
                end
            end
        end
    end

    // Monitor: every instruction decode consumes must be the next expected PC.
    initial forever begin
        @(negedge clk);
        #4;
        if (!rst && imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (!rst && !redirect_valid && instr_valid && instr_ready) begin
            consumed++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                mexp = exp_q.pop_front();
                check("sb_pc", instr_pc, mexp);
                check("sb_data", instr_data, mem_word(mexp));
                check("sb_pc_plus4", instr_pc_plus4, mexp + 32'd4);
            end
        end
    end

    initial begin
        int c0;
        int since;
        int r;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;

        tick(2);
        #4;
        check_reset_outputs("reset");

        tick(1);
        rst = 1'b0;
        push_seq(RPC);
        req_log.delete();
        #4;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RPC);
        tick(1); #4;
        check("latency_c1_invalid", 32'(instr_valid), 32'd0);
        tick(1); #4;
        check("latency_c2_valid", 32'(instr_valid), 32'd1);
        check("latency_c2_pc", instr_pc, RPC);
        tick(1);
        c0 = consumed;
        tick(20);
        check("throughput_20", 32'(consumed - c0), 32'd20);

        // Backpressure from decode
        do_reset();
        instr_ready = 1'b0;
        tick(10);
        check("bp_req_count", 32'(req_log.size()), 32'(QD));
        #4;
        check("bp_req_idle", 32'(imem_req_valid), 32'd0);
        check("bp_head_pc", instr_pc, RPC);
        tick(1);
        instr_ready = 1'b1;
        c0 = consumed;
        tick(12);
        check("bp_drain", 32'(consumed - c0 >= 10), 32'd1);

        // Redirect with two requests outstanding on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset();
        tick(2);
        redirect(32'h0000_0103);
        #4;
        check("rd_instr_invalid", 32'(instr_valid), 32'd0);
        check("rd_req_idle_1", 32'(imem_req_valid), 32'd0);
        tick(1); #4;
        check("rd_req_idle_2", 32'(imem_req_valid), 32'd0);
        tick(1); #4;
        check("rd_req_valid", 32'(imem_req_valid), 32'd1);
        check("rd_req_addr", imem_req_addr, 32'h0000_0100);
        c0 = consumed;
        tick(12);
        check("rd_progress", 32'(consumed - c0 > 0), 32'd1);

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset();
        tick(6);
        redirect(32'h0000_0200);
        #4;
        check("co_instr_invalid", 32'(instr_valid), 32'd0);
        check("co_req_valid", 32'(imem_req_valid), 32'd1);
        check("co_req_addr", imem_req_addr, 32'h0000_0200);
        tick(10);

        // PC wrap
        req_log.delete();
        redirect(32'hFFFF_FFF8);
        tick(8);
        if (req_log.size() >= 3) begin
            check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", req_log[2], 32'h0000_0000);
        end else begin
            check("wrap_req_count", 32'(req_log.size()), 32'd3);
        end

        // Reset while flushing stale responses
        lat_min = 3; lat_max = 3;
        do_reset();
        tick(2);
        redirect(32'h0000_0040);
        rst = 1'b1;
        exp_q.delete();
        tick(1); #4;
        check_reset_outputs("flush_reset");
        tick(1);
        rst = 1'b0;
        lat_min = 1; lat_max = 1;
        push_seq(RPC);
        #4;
        check("flush_reset_req_valid", 32'(imem_req_valid), 32'd1);
        check("flush_reset_req_addr", imem_req_addr, RPC);
        tick(10);

        // Randomized traffic
        lat_min = 1; lat_max = 4; ready_pct = 70;
        since = 0;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(99) < 75);
            r = int'($urandom_range(999));
            if (r < 3) begin
                do_reset();
                since = 0;
            end else if (r < 25 || since > 150) begin
                redirect($urandom);
                since = 0;
            end else begin
                tick(1);
                since++;
            end
        end
        ready_pct = 100;
        instr_ready = 1'b1;
        tick(20);
        check("random_progress", 32'(consumed - c0 > 500), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
